// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master: FSM states, frame opcodes and widths.
package spi_master_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StCmd,
    StShift,
    StHold,
    StWaitRd,
    StRead,
    StGap
  } spi_master_state_e;

endpackage

// File: rtl/spi_master_shreg.sv
// Parallel-load shift register, MSB first; shifts in zeros or a serial bit at the LSB.
module spi_master_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_out_i,
  input  logic             shift_in_i,
  input  logic [Width-1:0] par_i,
  input  logic             ser_i,
  output logic [Width-1:0] par_o,
  output logic             ser_o
);

  logic [Width-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = par_i;
    end else if (shift_in_i) begin
      sh_d = {sh_q[Width-2:0], ser_i};
    end else if (shift_out_i) begin
      sh_d = {sh_q[Width-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign par_o = sh_q;
  assign ser_o = sh_q[Width-1];

endmodule

// File: rtl/spi_master.sv
// SPI master: serialises 10-bit frames onto SS_n/MOSI and captures a read byte from MISO.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned RD_WAIT  = 3,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  localparam logic [3:0] WaitLoad = (RD_WAIT > 1) ? 4'(RD_WAIT - 2) : 4'd0;
  localparam logic [3:0] GapLoad  = 4'(IDLE_GAP - 1);

  spi_master_state_e state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic               tx_load, tx_shift, rx_shift, tx_ser, rx_ser;
  logic [FRAME_W-1:0] tx_par;
  logic [DATA_W-1:0]  rx_par;
  logic               unused_bits;

  spi_master_shreg #(.Width(FRAME_W)) u_tx_shreg (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (tx_load),
    .shift_out_i (tx_shift),
    .shift_in_i  (1'b0),
    .par_i       (frame),
    .ser_i       (1'b0),
    .par_o       (tx_par),
    .ser_o       (tx_ser)
  );

  spi_master_shreg #(.Width(DATA_W)) u_rx_shreg (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (1'b0),
    .shift_out_i (1'b0),
    .shift_in_i  (rx_shift),
    .par_i       ('0),
    .ser_i       (MISO),
    .par_o       (rx_par),
    .ser_o       (rx_ser)
  );

  assign unused_bits = ^{tx_par, rx_ser, rx_par[DATA_W-1]};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ss_n_d     = ss_n_q;
    mosi_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    ready_d    = ready_q;
    rd_data_d  = rd_data_q;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && ready_q) begin
          state_d = StSel;
          op_d    = frame[FRAME_W-1 -: 2];
          tx_load = 1'b1;
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      StSel: begin
        state_d   = StCmd;
        mosi_d    = tx_ser;
        bit_cnt_d = 4'd9;
      end
      // The command bit is sent twice: once for CHK_CMD, then again as the frame MSB.
      StCmd: begin
        state_d  = StShift;
        mosi_d   = tx_ser;
        tx_shift = 1'b1;
      end
      StShift: begin
        if (bit_cnt_q == 4'd0) begin
          state_d = StHold;
        end else begin
          mosi_d    = tx_ser;
          tx_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (op_q != OP_RD_DATA) begin
          state_d   = StGap;
          ss_n_d    = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          gap_cnt_d = GapLoad;
        end else if (RD_WAIT <= 1) begin
          state_d   = StRead;
          bit_cnt_d = 4'd7;
        end else begin
          state_d    = StWaitRd;
          wait_cnt_d = WaitLoad;
        end
      end
      StWaitRd: begin
        if (wait_cnt_q == 4'd0) begin
          state_d   = StRead;
          bit_cnt_d = 4'd7;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StRead: begin
        rx_shift = 1'b1;
        if (bit_cnt_q == 4'd0) begin
          rd_data_d  = {rx_par[DATA_W-2:0], MISO};
          rd_valid_d = 1'b1;
          done_d     = 1'b1;
          ss_n_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = StGap;
          gap_cnt_d  = GapLoad;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      bit_cnt_q  <= 4'd0;
      wait_cnt_q <= 4'd0;
      gap_cnt_q  <= 4'd0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign ready    = ready_q;
  assign rd_data  = rd_data_q;

endmodule
